// File: rtl/pwm_ctrl_pkg.sv
// Shared widths, limits and debouncer state encoding for the PWM operator-input stage.
// Also holds the one-step slew helper that moves speed toward target.
package pwm_ctrl_pkg;

  localparam int SPEED_W = 3;
  localparam logic [SPEED_W-1:0] SPEED_MAX = 3'd7;
  localparam int DB_CNT_W = 16;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_PRESS_WAIT,
    DB_HELD,
    DB_RELEASE_WAIT
  } db_state_t;

  function automatic logic [SPEED_W-1:0] step_toward(input logic [SPEED_W-1:0] cur,
                                                     input logic [SPEED_W-1:0] tgt);
    if (tgt > cur)      return cur + SPEED_W'(1);
    else if (tgt < cur) return cur - SPEED_W'(1);
    else                return cur;
  endfunction

endpackage

// File: rtl/pwm_btn_debounce.sv
// Button conditioner: 2-flop sync + stability debounce; press pulse 2+DB_CYCLES cycles after raw edge.
// No backpressure: press is a single-cycle strobe, level is the accepted debounced state.
module pwm_btn_debounce
  import pwm_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press
);

  localparam logic [DB_CNT_W-1:0] CNT_LAST = DB_CNT_W'(DB_CYCLES - 1);

  logic [1:0]          sync;
  logic                lvl;
  db_state_t           state, state_nxt;
  logic [DB_CNT_W-1:0] cnt, cnt_nxt;

  assign lvl = sync[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync  <= '0;
      state <= DB_IDLE;
      cnt   <= '0;
    end else begin
      sync  <= {sync[0], btn};
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Press pulse is Mealy: it fires in the cycle the FSM commits to HELD.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    press     = 1'b0;
    case (state)
      DB_IDLE: begin
        cnt_nxt = '0;
        if (lvl) state_nxt = DB_PRESS_WAIT;
      end
      DB_PRESS_WAIT: begin
        if (!lvl) begin
          state_nxt = DB_IDLE;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DB_HELD;
          cnt_nxt   = '0;
          press     = 1'b1;
        end else begin
          cnt_nxt = cnt + DB_CNT_W'(1);
        end
      end
      DB_HELD: begin
        cnt_nxt = '0;
        if (!lvl) state_nxt = DB_RELEASE_WAIT;
      end
      DB_RELEASE_WAIT: begin
        if (lvl) begin
          state_nxt = DB_HELD;
          cnt_nxt   = '0;
        end else if (cnt == CNT_LAST) begin
          state_nxt = DB_IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + DB_CNT_W'(1);
        end
      end
      default: begin
        state_nxt = DB_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign level = (state == DB_HELD) || (state == DB_RELEASE_WAIT);

endmodule

// File: rtl/pwm_speed_ctrl.sv
// Operator input for the PWM core: debounced up/dn/run -> saturating target, slewed speed, run toggle.
// PWM_SPEED_RAMP_EN: speed steps toward target every RAMP_DIV cycles; otherwise speed = target delayed 1 cycle.
module pwm_speed_ctrl
  import pwm_ctrl_pkg::*;
#(
  parameter int                 DB_CYCLES  = 50000,
  parameter int                 RAMP_DIV   = 500000,
  parameter logic [SPEED_W-1:0] SPEED_INIT = 3'd0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               btn_up,
  input  logic               btn_dn,
  input  logic               btn_run,
  output logic [SPEED_W-1:0] speed,
  output logic               pwm_en,
  output logic [SPEED_W-1:0] target,
  output logic               busy
);

  logic       up_p, dn_p, run_p;
  logic [2:0] unused_lvl;

  pwm_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_up (
    .clk(clk), .rst_n(rst_n), .btn(btn_up),  .level(unused_lvl[0]), .press(up_p)
  );
  pwm_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_dn (
    .clk(clk), .rst_n(rst_n), .btn(btn_dn),  .level(unused_lvl[1]), .press(dn_p)
  );
  pwm_btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_run (
    .clk(clk), .rst_n(rst_n), .btn(btn_run), .level(unused_lvl[2]), .press(run_p)
  );

  // Simultaneous up and down cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      target <= SPEED_INIT;
      pwm_en <= 1'b0;
    end else begin
      if (up_p && !dn_p && target != SPEED_MAX)
        target <= target + SPEED_W'(1);
      else if (dn_p && !up_p && target != '0)
        target <= target - SPEED_W'(1);
      if (run_p)
        pwm_en <= ~pwm_en;
    end
  end

`ifdef PWM_SPEED_RAMP_EN
  localparam int RAMP_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_DIV - 1);

  logic [RAMP_W-1:0] ramp_cnt;

  // Ramp phase survives target changes; direction is picked fresh at each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ramp_cnt <= '0;
      speed    <= SPEED_INIT;
    end else if (speed == target) begin
      ramp_cnt <= '0;
    end else if (ramp_cnt == RAMP_LAST) begin
      ramp_cnt <= '0;
      speed    <= step_toward(speed, target);
    end else begin
      ramp_cnt <= ramp_cnt + RAMP_W'(1);
    end
  end
`else
  logic unused_ramp;
  assign unused_ramp = (RAMP_DIV > 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) speed <= SPEED_INIT;
    else        speed <= target;
  end
`endif

  assign busy = (speed != target);

endmodule
